// File: rtl/core.sv
// Shared core-level types and constants for TachyonCore blocks.
package core;

   localparam int RF_ADDR_WIDTH   = 5;
   localparam int REG_WIDTH       = 32;
   localparam int DBG_RF_MAX_WAIT = 8;

   typedef enum logic [2:0] {
      IDLE,
      PEND,
      STALL,
      RDATA,
      ACK
   } RfArbState;

endpackage

// File: rtl/rf_port_arbiter.sv
// Shares the RF write port and read port 2 between the pipeline and the debug path.
// Pipeline wins every contested cycle; a starved debug access eventually forces a pipeline stall.
module rf_port_arbiter
   import core::*;
#(
   parameter int RF_ADDR_WIDTH = core::RF_ADDR_WIDTH,
   parameter int REG_WIDTH     = core::REG_WIDTH,
   parameter int MAX_WAIT      = core::DBG_RF_MAX_WAIT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_wr_en,
   input  logic [RF_ADDR_WIDTH-1:0] wb_wr_addr,
   input  logic [REG_WIDTH-1:0]     wb_wr_val,
   input  logic                     pipe_rd2_en,
   input  logic [RF_ADDR_WIDTH-1:0] pipe_rd2_addr,
   input  logic                     dbg_req,
   input  logic                     dbg_wr_rd,
   input  logic [RF_ADDR_WIDTH-1:0] dbg_addr,
   input  logic [REG_WIDTH-1:0]     dbg_wdata,
   output logic                     dbg_ack,
   output logic [REG_WIDTH-1:0]     dbg_rdata,
   output logic                     dbg_busy,
   output logic                     dbg_overrun,
   output logic                     pipe_stall,
   output logic                     rf_wr_en,
   output logic [RF_ADDR_WIDTH-1:0] rf_wr_addr,
   output logic [REG_WIDTH-1:0]     rf_wr_val,
   output logic [RF_ADDR_WIDTH-1:0] rf_rd2_addr,
   input  logic [REG_WIDTH-1:0]     rf_rd2_val
);

   localparam int CNT_WIDTH = $clog2(MAX_WAIT) + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_WAIT - 1);

   generate
      if (MAX_WAIT < 1) begin : g_bad_max_wait
         $error("rf_port_arbiter: MAX_WAIT must be >= 1");
      end
   endgenerate

   RfArbState                state, state_next;
   logic [CNT_WIDTH-1:0]     wait_cnt, wait_next;
   logic                     hold_wr;
   logic [RF_ADDR_WIDTH-1:0] hold_addr;
   logic [REG_WIDTH-1:0]     hold_wdata;
   logic                     contending;
   logic                     port_free;
   logic                     dbg_owns_wr;
   logic                     dbg_owns_rd;

   // Only the latched request reaches the RF, never the live dbg_* inputs.
   assign contending  = (state == PEND) || (state == STALL);
   assign port_free   = hold_wr ? !wb_wr_en : !pipe_rd2_en;
   assign dbg_owns_wr = contending && hold_wr && !wb_wr_en;
   assign dbg_owns_rd = contending && !hold_wr && !pipe_rd2_en;

   assign rf_wr_en    = dbg_owns_wr ? 1'b1       : wb_wr_en;
   assign rf_wr_addr  = dbg_owns_wr ? hold_addr  : wb_wr_addr;
   assign rf_wr_val   = dbg_owns_wr ? hold_wdata : wb_wr_val;
   assign rf_rd2_addr = dbg_owns_rd ? hold_addr  : pipe_rd2_addr;
   assign dbg_busy    = (state != IDLE);

   always_comb begin
      state_next = state;
      wait_next  = wait_cnt;
      case (state)
         IDLE: begin
            wait_next = '0;
            if (dbg_req) state_next = PEND;
         end
         PEND: begin
            if (port_free) begin
               state_next = hold_wr ? ACK : RDATA;
            end else if (wait_cnt == CNT_LAST) begin
               state_next = STALL;
            end else begin
               wait_next = wait_cnt + CNT_WIDTH'(1);
            end
         end
         STALL: begin
            if (port_free) state_next = hold_wr ? ACK : RDATA;
         end
         RDATA: state_next = ACK;
         ACK: begin
            state_next = IDLE;
            wait_next  = '0;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         hold_wr     <= 1'b0;
         hold_addr   <= '0;
         hold_wdata  <= '0;
         dbg_ack     <= 1'b0;
         dbg_rdata   <= '0;
         dbg_overrun <= 1'b0;
         pipe_stall  <= 1'b0;
      end else begin
         state      <= state_next;
         wait_cnt   <= wait_next;
         dbg_ack    <= (state_next == ACK);
         pipe_stall <= (state_next == STALL);
         if (dbg_req && (state == IDLE)) begin
            hold_wr    <= dbg_wr_rd;
            hold_addr  <= dbg_addr;
            hold_wdata <= dbg_wdata;
         end
         // A request while an access is outstanding is dropped but remembered.
         if (dbg_req && (state != IDLE)) dbg_overrun <= 1'b1;
         if (state == RDATA) dbg_rdata <= rf_rd2_val;
      end
   end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: RF model, directed scenarios and randomized debug traffic
// checked against a transaction-level timing model.
module tb_rf_port_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int MW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_wr_en;
   logic [AW-1:0] wb_wr_addr;
   logic [DW-1:0] wb_wr_val;
   logic          pipe_rd2_en;
   logic [AW-1:0] pipe_rd2_addr;
   logic          dbg_req;
   logic          dbg_wr_rd;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_ack;
   logic [DW-1:0] dbg_rdata;
   logic          dbg_busy;
   logic          dbg_overrun;
   logic          pipe_stall;
   logic          rf_wr_en;
   logic [AW-1:0] rf_wr_addr;
   logic [DW-1:0] rf_wr_val;
   logic [AW-1:0] rf_rd2_addr;
   logic [DW-1:0] rf_rd2_val;

   always #5 clk = ~clk;

   rf_port_arbiter #(.RF_ADDR_WIDTH(AW), .REG_WIDTH(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_val(wb_wr_val),
      .pipe_rd2_en(pipe_rd2_en), .pipe_rd2_addr(pipe_rd2_addr),
      .dbg_req(dbg_req), .dbg_wr_rd(dbg_wr_rd), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_busy(dbg_busy),
      .dbg_overrun(dbg_overrun), .pipe_stall(pipe_stall),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_val(rf_wr_val),
      .rf_rd2_addr(rf_rd2_addr), .rf_rd2_val(rf_rd2_val)
   );

   // Register file: x0 reads zero, read data arrives one cycle after the address.
   logic [DW-1:0] mem [32];
   always @(posedge clk) begin
      rf_rd2_val <= (rf_rd2_addr == '0) ? '0 : mem[rf_rd2_addr];
      if (rf_wr_en && rf_wr_addr != '0) mem[rf_wr_addr] <= rf_wr_val;
   end

   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;
   logic [DW-1:0] ref_mem [32];
   logic [DW-1:0] rdata_exp;
   logic          ovr_exp;
   logic          quiet;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=0x%08h expected=0x%08h", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // One debug access issued at k=0; the contested port is busy for k=1..nbusy and free at
   // k=nbusy+1, so the grant lands there; a stray request is injected at k=ovr_at.
   task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int nbusy, input int ovr_at);
      int            g;
      int            ack_k;
      logic          contested;
      logic          gw;
      logic          gr;
      logic          exp_wen;
      logic [AW-1:0] exp_waddr;
      logic [DW-1:0] exp_wval;
      logic [AW-1:0] exp_raddr;
      logic [DW-1:0] rd_snap;
      g       = nbusy + 1;
      ack_k   = wr ? g + 1 : g + 2;
      rd_snap = '0;
      for (int k = 0; k <= ack_k + 1; k++) begin
         dbg_req   = (k == 0) || (k == ovr_at);
         dbg_wr_rd = (k == 0) ? wr : 1'($urandom);
         dbg_addr  = (k == 0) ? addr : AW'($urandom);
         dbg_wdata = (k == 0) ? wdata : $urandom;
         if (k >= 1 && k <= nbusy) contested = 1'b1;
         else if (k == g)          contested = 1'b0;
         else                      contested = quiet ? 1'b0 : 1'($urandom);
         wb_wr_en      = wr ? contested : (quiet ? 1'b0 : 1'($urandom));
         pipe_rd2_en   = wr ? (quiet ? 1'b0 : 1'($urandom)) : contested;
         wb_wr_addr    = AW'($urandom);
         wb_wr_val     = $urandom;
         pipe_rd2_addr = AW'($urandom);
         #1;
         gw        = wr && (k == g);
         gr        = !wr && (k == g);
         exp_wen   = gw ? 1'b1  : wb_wr_en;
         exp_waddr = gw ? addr  : wb_wr_addr;
         exp_wval  = gw ? wdata : wb_wr_val;
         exp_raddr = gr ? addr  : pipe_rd2_addr;
         if (gr) rd_snap = ref_mem[addr];
         if (!wr && k == ack_k) rdata_exp = rd_snap;
         chk("dbg_busy",    DW'(dbg_busy),    DW'(k >= 1 && k <= ack_k));
         chk("dbg_ack",     DW'(dbg_ack),     DW'(k == ack_k));
         chk("pipe_stall",  DW'(pipe_stall),  DW'(k >= 1 + MW && k <= g));
         chk("dbg_overrun", DW'(dbg_overrun), DW'(ovr_exp));
         chk("dbg_rdata",   dbg_rdata,        rdata_exp);
         chk("rf_wr_en",    DW'(rf_wr_en),    DW'(exp_wen));
         chk("rf_wr_addr",  DW'(rf_wr_addr),  DW'(exp_waddr));
         chk("rf_wr_val",   rf_wr_val,        exp_wval);
         chk("rf_rd2_addr", DW'(rf_rd2_addr), DW'(exp_raddr));
         if (dbg_req && k >= 1 && k <= ack_k) ovr_exp = 1'b1;
         if (exp_wen && exp_waddr != '0) ref_mem[exp_waddr] = exp_wval;
         tick();
      end
   endtask

   initial begin
      logic          wr;
      logic [AW-1:0] addr;
      int            nb;
      int            ack;
      int            sel;
      int            ovr_at;

      rst = 1'b1;
      wb_wr_en = 1'b0; wb_wr_addr = '0; wb_wr_val = '0;
      pipe_rd2_en = 1'b0; pipe_rd2_addr = '0;
      dbg_req = 1'b0; dbg_wr_rd = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      quiet = 1'b1; ovr_exp = 1'b0; rdata_exp = '0;
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;

      // Reset values, RF outputs following the pipeline.
      tick();
      tick();
      wb_wr_en = 1'b1; wb_wr_addr = 5'd3; wb_wr_val = 32'hA5A5_0003;
      pipe_rd2_addr = 5'd17;
      #1;
      chk("rst_dbg_ack",     DW'(dbg_ack),     '0);
      chk("rst_dbg_rdata",   dbg_rdata,        '0);
      chk("rst_dbg_busy",    DW'(dbg_busy),    '0);
      chk("rst_dbg_overrun", DW'(dbg_overrun), '0);
      chk("rst_pipe_stall",  DW'(pipe_stall),  '0);
      chk("rst_rf_wr_en",    DW'(rf_wr_en),    32'd1);
      chk("rst_rf_wr_addr",  DW'(rf_wr_addr),  32'd3);
      chk("rst_rf_wr_val",   rf_wr_val,        32'hA5A5_0003);
      chk("rst_rf_rd2_addr", DW'(rf_rd2_addr), 32'd17);
      wb_wr_en = 1'b0;
      rst = 1'b0;
      tick();

      // Preload the RF through the pipeline write port; x7 gets a known value.
      for (int i = 1; i < 32; i++) begin
         wb_wr_en   = 1'b1;
         wb_wr_addr = AW'(i);
         wb_wr_val  = (i == 7) ? 32'h0000_1234 : $urandom;
         #1;
         chk("pre_rf_wr_addr", DW'(rf_wr_addr), DW'(wb_wr_addr));
         chk("pre_rf_wr_val",  rf_wr_val,       wb_wr_val);
         ref_mem[i] = wb_wr_val;
         tick();
      end
      wb_wr_en = 1'b0;

      // Idle-port write, then read back.
      do_txn(1'b1, 5'd5, 32'hDEAD_BEEF, 0, -1);
      do_txn(1'b0, 5'd5, '0, 0, -1);
      chk("readback_x5", dbg_rdata, 32'hDEAD_BEEF);
      // Idle-port read of the preloaded register.
      do_txn(1'b0, 5'd7, '0, 0, -1);
      chk("read_x7", dbg_rdata, 32'h0000_1234);
      // Write contention for three cycles, no stall.
      do_txn(1'b1, 5'd9, 32'h0BAD_F00D, 3, -1);
      // Forced stall: read port busy for ten cycles.
      do_txn(1'b0, 5'd7, '0, 10, -1);
      chk("stall_read_x7", dbg_rdata, 32'h0000_1234);
      // Write port held busy exactly long enough to reach the stall threshold.
      do_txn(1'b1, 5'd12, 32'h1357_9BDF, MW, -1);
      // Debug write to x0 passes through; x0 still reads zero.
      do_txn(1'b1, 5'd0, 32'hFFFF_FFFF, 0, -1);
      do_txn(1'b0, 5'd0, '0, 0, -1);
      chk("read_x0", dbg_rdata, '0);
      // Overrun: second request on the cycle after the first.
      do_txn(1'b1, 5'd3, 32'h3333_3333, 0, 1);
      chk("overrun_sticky", DW'(dbg_overrun), 32'd1);
      do_txn(1'b0, 5'd3, '0, 0, -1);
      chk("overrun_first_wins", dbg_rdata, 32'h3333_3333);

      // Randomized traffic with live pipeline activity.
      quiet = 1'b0;
      for (int t = 0; t < 40; t++) begin
         wr   = 1'($urandom);
         addr = AW'($urandom);
         nb   = int'($urandom_range(0, 12));
         ack  = wr ? nb + 2 : nb + 3;
         sel  = int'($urandom_range(0, 3));
         if (sel == 0)      ovr_at = int'($urandom_range(1, ack));
         else if (sel == 1) ovr_at = ack;
         else               ovr_at = -1;
         do_txn(wr, addr, $urandom, nb, ovr_at);
      end

      // Reset while in RDATA: everything clears before the next edge, no ack follows.
      quiet = 1'b1;
      wb_wr_en = 1'b0; pipe_rd2_en = 1'b0;
      dbg_req = 1'b1; dbg_wr_rd = 1'b0; dbg_addr = 5'd7;
      tick();
      dbg_req = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      wb_wr_en = 1'b1; wb_wr_addr = 5'd20; wb_wr_val = 32'h2020_2020;
      #1;
      chk("mid_rst_dbg_ack",     DW'(dbg_ack),     '0);
      chk("mid_rst_dbg_rdata",   dbg_rdata,        '0);
      chk("mid_rst_dbg_busy",    DW'(dbg_busy),    '0);
      chk("mid_rst_dbg_overrun", DW'(dbg_overrun), '0);
      chk("mid_rst_pipe_stall",  DW'(pipe_stall),  '0);
      chk("mid_rst_rf_wr_en",    DW'(rf_wr_en),    32'd1);
      chk("mid_rst_rf_wr_addr",  DW'(rf_wr_addr),  32'd20);
      chk("mid_rst_rf_wr_val",   rf_wr_val,        32'h2020_2020);
      wb_wr_en = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("post_rst_dbg_ack",  DW'(dbg_ack),  '0);
         chk("post_rst_dbg_busy", DW'(dbg_busy), '0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rf_port_arbiter.md
# rf_port_arbiter

Shares TachyonRegFile write port and read port 2 between the in-order pipeline (Writeback, ReadStage) and the debug register path behind CoreDbgApb. Pipeline traffic has priority. A debug access waits for a free slot. After `MAX_WAIT` lost cycles it raises `pipe_stall` to force a slot. Sits in TachyonCore between the debug-request decode and `_rf`.

## Interface
- `RF_ADDR_WIDTH`, default `core::RF_ADDR_WIDTH` (5): register index width.
- `REG_WIDTH`, default `core::REG_WIDTH` (32): register data width.
- `MAX_WAIT`, default 8: number of lost arbitration cycles before a stall is forced. Must be >= 1; elaboration error otherwise.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `wb_wr_en`, `wb_wr_addr`, `wb_wr_val`  in  1/RF_ADDR_WIDTH/REG_WIDTH  Writeback write request.
- `pipe_rd2_en`, `pipe_rd2_addr`  in  1/RF_ADDR_WIDTH  ReadStage use of read port 2.
- `dbg_req`  in  1  single-cycle debug access request.
- `dbg_wr_rd`  in  1  1 = write, 0 = read.
- `dbg_addr`  in  RF_ADDR_WIDTH  target register.
- `dbg_wdata`  in  REG_WIDTH  write data.
- `dbg_ack`  out  1  registered completion pulse.
- `dbg_rdata`  out  REG_WIDTH  read result; held until the next read ack.
- `dbg_busy`  out  1  an access is outstanding.
- `dbg_overrun`  out  1  sticky flag: a request arrived while busy.
- `pipe_stall`  out  1  registered stall request to the pipeline.
- `rf_wr_en`, `rf_wr_addr`, `rf_wr_val`  out  1/RF_ADDR_WIDTH/REG_WIDTH  to the RF write port.
- `rf_rd2_addr`  out  RF_ADDR_WIDTH  to RF read port 2.
- `rf_rd2_val`  in  REG_WIDTH  RF read port 2 data, valid one cycle after the address.

## Operation
- **Request capture.** `dbg_req` in IDLE latches `dbg_wr_rd`, `dbg_addr` and `dbg_wdata` into holding registers and moves to PEND.
  - A `dbg_req` in any other state is dropped and sets `dbg_overrun`.
  - `dbg_overrun` clears only on `rst`.
- **States:** IDLE, PEND, STALL, RDATA, ACK.
- **PEND.**
  - Write: if `wb_wr_en`=0, drive the RF write port from the holding registers this cycle (the grant), then go to ACK.
  - Read: if `pipe_rd2_en`=0, drive `rf_rd2_addr` from the holding register (the grant), then go to RDATA.
  - Lost cycle: increment `wait_cnt`. When `wait_cnt` reaches `MAX_WAIT`-1 on a lost cycle, go to STALL.
- **STALL.**
  - `pipe_stall`=1.
  - Grant under the same free-port rule as PEND.
  - `pipe_stall` deasserts on the cycle after the grant.
- **RDATA.** Capture `rf_rd2_val` into `dbg_rdata`, then go to ACK.
- **ACK.** `dbg_ack`=1 for one cycle, then go to IDLE. `wait_cnt` clears.
- **Port muxing.**
  - When the pipeline owns a port, the RF sees the pipeline signals unchanged (`rf_wr_en`=`wb_wr_en`).
  - When debug owns the write port, `rf_wr_en`=1.
  - A debug write to x0 is passed through; RF semantics apply.
- **Combinational path.** The mux outputs are combinational from the current state and inputs. No combinational path exists from `dbg_*` inputs to `rf_*` outputs.
- **`dbg_busy`.** Equals (state != IDLE).

## Timing
- **Reset values:** state IDLE, `dbg_ack`=0, `dbg_rdata`=0, `dbg_busy`=0, `dbg_overrun`=0, `pipe_stall`=0, `wait_cnt`=0. RF port outputs follow the pipeline inputs.
- **Write latency, port free:** `dbg_req` at cycle N → grant at N+1 → `dbg_ack` at N+2.
- **Read latency, port free:** `dbg_req` at N → address at N+1 → capture at N+2 → `dbg_ack` and `dbg_rdata` at N+3.
- **Forced stall:** with the port continuously busy, STALL is entered at N+1+`MAX_WAIT`. `pipe_stall` is high from that cycle until one cycle after the grant.
- **Simultaneous events:**
  - A pipeline request always beats a PEND/STALL debug access in the same cycle.
  - A `dbg_req` coinciding with `dbg_ack` is an overrun. It is dropped.
- **Reset mid-access:** the access is abandoned, with no ack and no RF write. Any RF write in the reset cycle is the pipeline's.
- **`wait_cnt` width** is $clog2(`MAX_WAIT`)+1. It never wraps.

## Structure
- Add to package `core`:
  - `typedef enum logic [2:0] RfArbState` {IDLE, PEND, STALL, RDATA, ACK}.
  - `localparam DBG_RF_MAX_WAIT = 8`.
- Single module; no sub-module. TachyonCore instantiates `rf_port_arbiter` and drives `_rf` write port and `rd_addr[2]` from it.

## Test plan
- **Idle-port write:** `dbg_req` write x5=0xDEADBEEF at cycle 10 → `rf_wr_en`=1, `rf_wr_addr`=5 at cycle 11; `dbg_ack` at 12; a later debug read of x5 returns 0xDEADBEEF.
- **Idle-port read:** x7 preloaded 0x00001234; read request at cycle 20 → `rf_rd2_addr`=7 at 21; `dbg_ack`=1 and `dbg_rdata`=0x00001234 at 23.
- **Contention:** `wb_wr_en`=1 for cycles 30–32 with a debug write pending from 30 → pipeline writes unaltered; debug grant at 33; ack at 34; `pipe_stall` never asserted.
- **Forced stall:** `MAX_WAIT`=8, `pipe_rd2_en` held high; read request at cycle 40 → `pipe_stall`=1 at 49; bench drops `pipe_rd2_en` at 51 → grant at 51, `pipe_stall`=0 at 52, ack at 53.
- **Overrun:** second `dbg_req` at the cycle after the first → `dbg_overrun`=1 and stays set; exactly one ack, for the first request.
- **Reset mid-access:** assert `rst` asynchronously while in RDATA → all outputs reach reset values before the next edge; no `dbg_ack` issued.
